// File: rtl/sized_data_mem.sv
// sized_data_mem: word-organised data memory for the pipeline data port.
// Handles RV32I byte/halfword/word loads and stores and takes a fixed
// number of wait cycles (LATENCY) per access. Misaligned, out-of-range
// and illegal accesses complete normally with err=1 and have no effect on
// the array.
//
// Handshake: the CPU raises mrd or mwr and holds adr/d_in/size stable while
// busy is high. busy = (mrd|mwr) & ~done, so it drops in the cycle where
// done pulses. That cycle is the CPU's cue to drop or change its request.
// Requests are only sampled in IDLE. The cycle after DONE is always IDLE.
//
// Optional build macro DMEM_STATS_EN adds saturating access counters
// rd_cnt, wr_cnt and err_cnt.
module sized_data_mem #(
   parameter int unsigned DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned LATENCY   = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] adr,
   input  logic [31:0] d_in,
   input  logic [2:0]  size,
   input  logic        mrd,
   input  logic        mwr,
   output logic        busy,
   output logic        done,
   output logic [31:0] d_out,
   output logic        err
`ifdef DMEM_STATS_EN
   ,
   output logic [31:0] rd_cnt,
   output logic [31:0] wr_cnt,
   output logic [31:0] err_cnt
`endif
);

   localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [31:0] adr_q;
   logic [31:0] din_q;
   logic [2:0]  size_q;
   logic        rd_q;
   logic        wr_q;
   logic        done_q;
   logic        err_q;
   logic [31:0] dout_q;

   logic [31:0] mem_q [DEPTH];

   logic [31:0] offset;
   logic [31:0] word_idx;
   logic [1:0]  lane;
   logic        in_range;
   logic        misaligned;
   logic        bad_size;
   logic        acc_err;
   logic [31:0] rd_word;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_d;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        commit;
   logic        wr_en;

   // Decode the captured request: error checks, load extension, store lanes.
   always_comb begin
      offset   = adr_q - BASE_ADDR;
      word_idx = offset >> 2;
      lane     = adr_q[1:0];
      in_range = (adr_q >= BASE_ADDR) && (word_idx < 32'(DEPTH));

      case (size_q[1:0])
         2'b01:   misaligned = lane[0];
         2'b10:   misaligned = (lane != 2'b00);
         default: misaligned = 1'b0;
      endcase

      // Unsigned sizes only make sense for loads.
      case (size_q)
         3'b000, 3'b001, 3'b010: bad_size = 1'b0;
         3'b100, 3'b101:         bad_size = wr_q;
         default:                bad_size = 1'b1;
      endcase

      acc_err = ~in_range | misaligned | bad_size | (rd_q & wr_q);

      rd_word  = mem_q[word_idx[AW-1:0]];
      byte_sel = rd_word[{lane, 3'b000} +: 8];
      half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

      case (size_q)
         3'b000:  load_d = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_d = {24'h0, byte_sel};
         3'b001:  load_d = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_d = {16'h0, half_sel};
         3'b010:  load_d = rd_word;
         default: load_d = 32'h0;
      endcase

      // Store data is replicated across lanes; be picks the lanes written.
      case (size_q[1:0])
         2'b00: begin
            wdata = {4{din_q[7:0]}};
            be    = 4'b0001 << lane;
         end
         2'b01: begin
            wdata = {2{din_q[15:0]}};
            be    = lane[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wdata = din_q;
            be    = 4'b1111;
         end
      endcase

      commit = (state_q == S_WAIT) && (cnt_q == 4'd0);
      wr_en  = commit & wr_q & ~acc_err & ~rst;
   end

   // Array write with byte enables; contents are never reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem_q[word_idx[AW-1:0]][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Access FSM: capture in IDLE, count down in WAIT, pulse done in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         dout_q  <= 32'h0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (mrd | mwr) begin
                  adr_q   <= adr;
                  din_q   <= d_in;
                  size_q  <= size;
                  rd_q    <= mrd;
                  wr_q    <= mwr;
                  cnt_q   <= CNT_INIT;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  done_q  <= 1'b1;
                  err_q   <= acc_err;
                  dout_q  <= (acc_err | wr_q) ? 32'h0 : load_d;
                  state_q <= S_DONE;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy  = (mrd | mwr) & ~done_q;
   assign done  = done_q;
   assign d_out = dout_q;
   assign err   = err_q;

`ifdef DMEM_STATS_EN
   logic [31:0] rd_cnt_q;
   logic [31:0] wr_cnt_q;
   logic [31:0] err_cnt_q;

   // Saturating per-outcome counters, bumped on the edge entering DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_cnt_q  <= 32'h0;
         wr_cnt_q  <= 32'h0;
         err_cnt_q <= 32'h0;
      end else if (commit) begin
         if (acc_err) begin
            if (err_cnt_q != 32'hFFFF_FFFF) err_cnt_q <= err_cnt_q + 32'd1;
         end else if (wr_q) begin
            if (wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_q <= wr_cnt_q + 32'd1;
         end else begin
            if (rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_q <= rd_cnt_q + 32'd1;
         end
      end
   end

   assign rd_cnt  = rd_cnt_q;
   assign wr_cnt  = wr_cnt_q;
   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_sized_data_mem.sv
// Directed bench for sized_data_mem: handshake timing, load extension,
// byte-lane stores, error cases, reset abort and (with DMEM_STATS_EN)
// the access counters.
module tb_sized_data_mem;

`ifdef DMEM_STATS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 3;
`endif
   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] adr;
   logic [31:0] d_in;
   logic [2:0]  size;
   logic        mrd;
   logic        mwr;
   logic        busy;
   logic        done;
   logic [31:0] d_out;
   logic        err;
`ifdef DMEM_STATS_EN
   logic [31:0] rd_cnt;
   logic [31:0] wr_cnt;
   logic [31:0] err_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] r_dout;
   logic        r_err;
   int          r_busy;
   int          r_done_at;
   logic        saw_done;

   sized_data_mem #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .LATENCY(LAT)) dut (
      .clk   (clk),
      .rst   (rst),
      .adr   (adr),
      .d_in  (d_in),
      .size  (size),
      .mrd   (mrd),
      .mwr   (mwr),
      .busy  (busy),
      .done  (done),
      .d_out (d_out),
      .err   (err)
`ifdef DMEM_STATS_EN
      ,
      .rd_cnt  (rd_cnt),
      .wr_cnt  (wr_cnt),
      .err_cnt (err_cnt)
`endif
   );

   // clock
   always #5 clk = ~clk;

   task check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One request held until done (or a cycle budget runs out).
   // Cycle 0 is the cycle the request first appears.
   task run_access(input logic rd, input logic wr, input logic [2:0] sz,
                   input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      mrd = rd; mwr = wr; size = sz; adr = a; d_in = d;
      r_busy = 0; r_done_at = -1; r_dout = 32'hxxxx_xxxx; r_err = 1'bx;
      for (int c = 0; c < LAT + 10; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (busy) r_busy++;
         if (done) begin
            r_done_at = c;
            r_dout = d_out;
            r_err = err;
            break;
         end
      end
      if (r_done_at < 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL timeout: no done for adr %h", a);
      end
      mrd = 1'b0; mwr = 1'b0;
   endtask

   task rd_chk(input string tag, input logic [2:0] sz, input logic [31:0] a,
               input logic [31:0] exp_d, input logic exp_e);
      run_access(1'b1, 1'b0, sz, a, 32'h0);
      check_eq({tag, "_dout"}, r_dout, exp_d);
      check_eq({tag, "_err"}, {31'h0, r_err}, {31'h0, exp_e});
   endtask

   task wr_chk(input string tag, input logic [2:0] sz, input logic [31:0] a,
               input logic [31:0] d, input logic exp_e);
      run_access(1'b0, 1'b1, sz, a, d);
      check_eq({tag, "_err"}, {31'h0, r_err}, {31'h0, exp_e});
      check_eq({tag, "_dout"}, r_dout, 32'h0);
   endtask

   initial begin
      rst = 1'b1; mrd = 1'b0; mwr = 1'b0; adr = 32'h0; d_in = 32'h0; size = 3'b010;
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_done", {31'h0, done}, 32'h0);
      check_eq("rst_err", {31'h0, err}, 32'h0);
      check_eq("rst_dout", d_out, 32'h0);
      rst = 1'b0;

      // SW with handshake timing
      run_access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
      check_eq("sw_busy_cycles", r_busy, LAT + 1);
      check_eq("sw_done_cycle", r_done_at, LAT + 1);
      check_eq("sw_err", {31'h0, r_err}, 32'h0);
      check_eq("sw_dout", r_dout, 32'h0);
      run_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
      check_eq("lw_done_cycle", r_done_at, LAT + 1);
      check_eq("lw_dout", r_dout, 32'hDEAD_BEEF);

      // byte store and extended loads
      wr_chk("sb12", 3'b000, 32'h12, 32'hAAAA_AA55, 1'b0);
      rd_chk("lw10", 3'b010, 32'h10, 32'hDE55_BEEF, 1'b0);
      rd_chk("lb13", 3'b000, 32'h13, 32'hFFFF_FFDE, 1'b0);
      rd_chk("lbu13", 3'b100, 32'h13, 32'h0000_00DE, 1'b0);
      rd_chk("lh12", 3'b001, 32'h12, 32'hFFFF_DE55, 1'b0);
      rd_chk("lhu10", 3'b101, 32'h10, 32'h0000_BEEF, 1'b0);
      rd_chk("lb10", 3'b000, 32'h10, 32'hFFFF_FFEF, 1'b0);

      // errors
      rd_chk("lw11_mis", 3'b010, 32'h11, 32'h0, 1'b1);
      check_eq("lw11_done_cycle", r_done_at, LAT + 1);
      wr_chk("sh13_mis", 3'b001, 32'h13, 32'h0000_1234, 1'b1);
      rd_chk("lw10_after_sh", 3'b010, 32'h10, 32'hDE55_BEEF, 1'b0);
      rd_chk("lw_oor", 3'b010, DEPTH * 4, 32'h0, 1'b1);
      rd_chk("ld_sz011", 3'b011, 32'h10, 32'h0, 1'b1);
      wr_chk("st_sz100", 3'b100, 32'h10, 32'h0000_0011, 1'b1);
      rd_chk("lw10_after_bad", 3'b010, 32'h10, 32'hDE55_BEEF, 1'b0);

      // both mrd and mwr
      wr_chk("sw20_init", 3'b010, 32'h20, 32'h0, 1'b0);
      run_access(1'b1, 1'b1, 3'b010, 32'h20, 32'h1);
      check_eq("both_err", {31'h0, r_err}, 32'h1);
      check_eq("both_dout", r_dout, 32'h0);
      rd_chk("lw20_after_both", 3'b010, 32'h20, 32'h0, 1'b0);
      wr_chk("sh22", 3'b001, 32'h22, 32'h1234_CAFE, 1'b0);
      rd_chk("lw20_after_sh", 3'b010, 32'h20, 32'hCAFE_0000, 1'b0);

      // reset during WAIT aborts a pending write
      wr_chk("sw30_init", 3'b010, 32'h30, 32'h1234_5678, 1'b0);
      rd_chk("lw10_pre_rst", 3'b010, 32'h10, 32'hDE55_BEEF, 1'b0);
      saw_done = 1'b0;
      @(negedge clk);
      mwr = 1'b1; size = 3'b010; adr = 32'h30; d_in = 32'hA5A5_A5A5;
      @(negedge clk);
      #1;
      saw_done = saw_done | done;
      rst = 1'b1; mwr = 1'b0;
      @(negedge clk);
      #1;
      saw_done = saw_done | done;
      rst = 1'b0;
      for (int c = 0; c < LAT + 3; c++) begin
         @(negedge clk);
         #1;
         saw_done = saw_done | done;
      end
      check_eq("rst_abort_no_done", {31'h0, saw_done}, 32'h0);
      check_eq("rst_abort_dout", d_out, 32'h0);
      check_eq("rst_abort_err", {31'h0, err}, 32'h0);
      rd_chk("lw30_after_rst", 3'b010, 32'h30, 32'h1234_5678, 1'b0);

`ifdef DMEM_STATS_EN
      // counters: lw30 above counted one read since the reset
      rst = 1'b1;
      @(negedge clk);
      #1;
      rst = 1'b0;
      check_eq("cnt_rd_clr0", rd_cnt, 32'h0);
      wr_chk("st_w40", 3'b010, 32'h40, 32'h8765_4321, 1'b0);
      wr_chk("st_w44", 3'b010, 32'h44, 32'h0000_F00D, 1'b0);
      rd_chk("st_lw40", 3'b010, 32'h40, 32'h8765_4321, 1'b0);
      rd_chk("st_lb41", 3'b000, 32'h41, 32'h0000_0043, 1'b0);
      rd_chk("st_lhu44", 3'b101, 32'h44, 32'h0000_F00D, 1'b0);
      rd_chk("st_lh41", 3'b001, 32'h41, 32'h0, 1'b1);
      @(negedge clk);
      #1;
      check_eq("cnt_wr", wr_cnt, 32'd2);
      check_eq("cnt_rd", rd_cnt, 32'd3);
      check_eq("cnt_err", err_cnt, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      #1;
      rst = 1'b0;
      check_eq("cnt_wr_clr", wr_cnt, 32'h0);
      check_eq("cnt_rd_clr", rd_cnt, 32'h0);
      check_eq("cnt_err_clr", err_cnt, 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
